lifo_stack_param: RTL and testbench
===================================

Name: lifo_stack_param

Overview:
- Parametrised synchronous LIFO stack, successor to the fixed 4-bit stack block.
- Generalises data width and depth; adds occupancy count, combinational top-of-stack peek, an almost-full threshold and a defined push+pop swap.
- Used as a scratch/return-address store and for operand stacking in the lab datapath experiments.

Parameters:
- DATA_WIDTH, 4, width of each stored word.
- DEPTH, 5, number of entries; legal range 2..256.
- AFULL_LEVEL, DEPTH-1, almost_full asserts when count >= AFULL_LEVEL; legal range 1..DEPTH.
- CW, $clog2(DEPTH+1), width of count; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstN  input  1  reset, synchronous, active-low.
- data_in  input  DATA_WIDTH  word to push.
- push  input  1  push request, sampled at rising edge.
- pop  input  1  pop request, sampled at rising edge.
- data_out  output  DATA_WIDTH  registered; last popped word.
- top  output  DATA_WIDTH  combinational peek of current top entry; 0 when empty.
- count  output  CW  registered number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_LEVEL.

Behaviour:
- One clock, rstN synchronous active-low.
- Reset (rstN=0 at edge):
  - count=0, data_out=0, empty=1, full=0, almost_full=0.
  - Memory contents need not be cleared; top reads 0 because the stack is empty.
  - Reset overrides push/pop in the same cycle.
  - Reset mid-sequence discards all entries.
- Storage: array of DEPTH words plus stack pointer sp = count. The top entry is mem[count-1].
- Status flags full, empty and almost_full decode directly from the registered count, so they update in the cycle after the operation.
- Operation resolved each edge (valid_pop = pop && !empty; valid_push = push):
  - push only, not full: mem[count] <= data_in; count+1.
  - push only, full: ignored; no state change (overflow).
  - pop only, not empty: data_out <= mem[count-1]; count-1. Popped data is visible one cycle after the pop edge.
  - pop only, empty: ignored; data_out holds (underflow).
  - push and pop, not empty (including full): swap.
    - data_out <= old top.
    - mem[count-1] <= data_in.
    - count unchanged.
  - push and pop, empty: pop is invalid, push performed; count becomes 1; data_out holds.
  - neither: hold all state.
- data_out changes only on a valid pop or swap; otherwise it holds its last value.
- Changes on data_in while push=0 have no effect.
- count never wraps: no transition from DEPTH to DEPTH+1 or from 0 to all-ones.

Optional Feature:
- Macro: LIFO_STACK_ERR_FLAGS_EN.
- Defined:
  - Adds outputs overflow and underflow (1 bit each, registered, sticky).
  - overflow sets on push-only while full.
  - underflow sets on pop while empty with no push.
  - Both flags clear only on reset.
- Undefined: these ports and their logic do not exist; the interface is exactly as listed above.

Test Plan:
- Reset then push 5 words (3,9,D,1,D), DEPTH=5 -> count steps 1..5; full=1 after the 5th edge; top=D; almost_full=1 from count=4.
- With the stack full, push-only of A -> count stays 5; top stays D. Then pop x3 -> data_out sequence D,1,D; count=2; top=9.
- Push 4 and pop in the same cycle with count=2 -> data_out=9; count=2; top=4. Next cycle pop-only -> data_out=4; count=1.
- Assert rstN=0 for one edge while push=1 -> count=0, empty=1, data_out=0. Then pop x2 -> no change; with ERR_FLAGS_EN, underflow=1.
- While empty, push E with pop=1 -> count=1, top=E, data_out unchanged. Next pop -> data_out=E, empty=1.
- Toggle data_in randomly for 3 cycles with push=pop=0 -> count, top and data_out all constant.

Source files
------------

// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO with occupancy count, top-of-stack peek, almost-full
// threshold and push+pop swap. Define LIFO_STACK_ERR_FLAGS_EN for sticky overflow/underflow.
module lifo_stack_param #(
  parameter int DATA_WIDTH  = 4,
  parameter int DEPTH       = 5,
  parameter int AFULL_LEVEL = DEPTH - 1,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] top,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
`ifdef LIFO_STACK_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  almost_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         top_idx;
  logic [AW-1:0]         cnt_idx;
  logic [DATA_WIDTH-1:0] top_word;
  logic                  full_w;
  logic                  empty_w;

  assign full_w   = (count_q == CW'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign cnt_idx  = AW'(count_q);
  assign top_idx  = AW'(count_q - CW'(1));
  assign top_word = mem_q[top_idx];

  always_comb begin
    count_d    = count_q;
    data_out_d = data_out_q;
    wr_en      = 1'b0;
    wr_addr    = cnt_idx;
    if (push && pop && !empty_w) begin
      // swap: old top leaves through data_out, new word takes its slot
      data_out_d = top_word;
      wr_en      = 1'b1;
      wr_addr    = top_idx;
    end else if (push) begin
      if (!full_w) begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (pop && !empty_w) begin
      data_out_d = top_word;
      count_d    = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // storage is never cleared; an empty stack masks whatever it holds
  always_ff @(posedge clk) begin
    if (rstN && wr_en) mem_q[wr_addr] <= data_in;
  end

`ifdef LIFO_STACK_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (push && !pop && full_w);
    underflow_d = underflow_q | (pop && !push && empty_w);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign data_out    = data_out_q;
  assign count       = count_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign almost_full = (count_q >= CW'(AFULL_LEVEL));
  assign top         = empty_w ? '0 : top_word;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Bench for lifo_stack_param: queue-based reference model checked every cycle,
// plus directed steps with literal expectations.
module tb_lifo_stack_param;

  localparam int DW    = 4;
  localparam int DEPTH = 5;
  localparam int AFL   = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_out;
  logic [DW-1:0] top;
  logic [CW-1:0] count;
  logic          full, empty, almost_full;
`ifdef LIFO_STACK_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  lifo_stack_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .rstN(rstN), .data_in(data_in), .push(push), .pop(pop),
    .data_out(data_out), .top(top), .count(count), .full(full), .empty(empty),
`ifdef LIFO_STACK_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // reference model: a plain queue of stored words, last element is the top
  int q[$];
  int m_dout = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always @(posedge clk) begin
    if (!rstN) begin
      q.delete();
      m_dout = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (push && pop && q.size() > 0) begin
      m_dout = q[$];
      q[$]   = int'(data_in);
    end else if (push) begin
      if (q.size() < DEPTH) q.push_back(int'(data_in));
      else m_ovf = 1'b1;
    end else if (pop) begin
      if (q.size() > 0) m_dout = q.pop_back();
      else m_unf = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_count", int'(count), q.size());
      check("m_empty", int'(empty), int'(q.size() == 0));
      check("m_full", int'(full), int'(q.size() == DEPTH));
      check("m_afull", int'(almost_full), int'(q.size() >= AFL));
      check("m_top", int'(top), (q.size() == 0) ? 0 : q[$]);
      check("m_dout", int'(data_out), m_dout);
`ifdef LIFO_STACK_ERR_FLAGS_EN
      check("m_ovf", int'(overflow), int'(m_ovf));
      check("m_unf", int'(underflow), int'(m_unf));
`endif
    end
  end

  task automatic step(input bit ps, input bit pp, input logic [DW-1:0] d);
    push    = ps;
    pop     = pp;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] fill_vals [5];
    fill_vals = '{4'h3, 4'h9, 4'hD, 4'h1, 4'hD};

    rstN = 1'b0;
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    rstN = 1'b1;
    chk_en = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_afull", int'(almost_full), 0);
    check("rst_dout", int'(data_out), 0);
    check("rst_top", int'(top), 0);

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, fill_vals[i]);
      check("fill_count", int'(count), i + 1);
      check("fill_afull", int'(almost_full), int'(i + 1 >= 4));
      check("fill_full", int'(full), int'(i == 4));
    end
    check("fill_top", int'(top), 'hD);

    step(1'b1, 1'b0, 4'hA);
    check("ovf_count", int'(count), 5);
    check("ovf_top", int'(top), 'hD);
`ifdef LIFO_STACK_ERR_FLAGS_EN
    check("ovf_flag", int'(overflow), 1);
`endif

    step(1'b0, 1'b1, 4'h0);
    check("pop1_dout", int'(data_out), 'hD);
    step(1'b0, 1'b1, 4'h0);
    check("pop2_dout", int'(data_out), 'h1);
    step(1'b0, 1'b1, 4'h0);
    check("pop3_dout", int'(data_out), 'hD);
    check("pop3_count", int'(count), 2);
    check("pop3_top", int'(top), 'h9);

    step(1'b1, 1'b1, 4'h4);
    check("swap_dout", int'(data_out), 'h9);
    check("swap_count", int'(count), 2);
    check("swap_top", int'(top), 'h4);
    step(1'b0, 1'b1, 4'h0);
    check("pop4_dout", int'(data_out), 'h4);
    check("pop4_count", int'(count), 1);

    rstN = 1'b0;
    step(1'b1, 1'b0, 4'h7);
    rstN = 1'b1;
    check("mrst_count", int'(count), 0);
    check("mrst_empty", int'(empty), 1);
    check("mrst_dout", int'(data_out), 0);
    step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 4'h0);
    check("unf_count", int'(count), 0);
    check("unf_dout", int'(data_out), 0);
`ifdef LIFO_STACK_ERR_FLAGS_EN
    check("unf_flag", int'(underflow), 1);
    check("unf_ovf_clr", int'(overflow), 0);
`endif

    step(1'b1, 1'b1, 4'hE);
    check("epp_count", int'(count), 1);
    check("epp_top", int'(top), 'hE);
    check("epp_dout", int'(data_out), 0);
    step(1'b0, 1'b1, 4'h0);
    check("epop_dout", int'(data_out), 'hE);
    check("epop_empty", int'(empty), 1);

    step(1'b1, 1'b0, 4'h7);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      check("idle_count", int'(count), 1);
      check("idle_top", int'(top), 'h7);
      check("idle_dout", int'(data_out), 'hE);
    end

    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h4);
    step(1'b1, 1'b0, 4'h6);
    step(1'b1, 1'b0, 4'h8);
    step(1'b1, 1'b1, 4'hB);
    check("fswap_dout", int'(data_out), 'h8);
    check("fswap_top", int'(top), 'hB);
    check("fswap_count", int'(count), 5);
    check("fswap_full", int'(full), 1);

    for (int i = 0; i < 400; i++) begin
      rstN = ($urandom_range(0, 59) != 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    rstN = 1'b1;
    step(1'b0, 1'b0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
